bus_slave_burst: RTL and testbench

- Parametrised bit-serial bus slave with burst read/write into an internal BRAM.
- Successor to the single-word serial slave; adds a burst-length field, incrementing burst addressing, gapless read streaming, out-of-range error flagging and asynchronous reset.
- Sits on the shared serial bus behind the arbiter, one instance per memory-mapped slave.

---
 rtl/bus_slave_pkg.sv | 18 +
 rtl/bus_slave_burst_if.sv | 24 ++
 rtl/bus_slave_burst_bram.sv | 22 ++
 rtl/bus_slave_burst.sv | 203 ++++++++++++++++++++
 tb/tb_bus_slave_burst.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_slave_pkg.sv
// rtl/bus_slave_pkg.sv - state encodings and header helpers shared by bus_slave_burst
package bus_slave_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] HDR    = 3'd1;
  localparam logic [2:0] WR     = 3'd2;
  localparam logic [2:0] RDWAIT = 3'd3;
  localparam logic [2:0] RD     = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  // Value latched into the sticky flag when a word falls outside the memory
  localparam logic ERR_RANGE = 1'b1;

  function automatic int hdrLen(input int adn, input int bln);
    return adn + bln;
  endfunction

endpackage

// File: rtl/bus_slave_burst_if.sv
// rtl/bus_slave_burst_if.sv - serial bus bundle between master/arbiter and bus_slave_burst
interface bus_slave_burst_if;

  logic validIn;
  logic wren;
  logic Address;
  logic DataIn;
  logic BusAvailable;
  logic ready;
  logic validOut;
  logic DataOut;
  logic err;

  modport master (
    output validIn, wren, Address, DataIn, BusAvailable,
    input  ready, validOut, DataOut, err
  );

  modport slave (
    input  validIn, wren, Address, DataIn, BusAvailable,
    output ready, validOut, DataOut, err
  );

endinterface

// File: rtl/bus_slave_burst_bram.sv
// rtl/bus_slave_burst_bram.sv - single-port BRAM with registered read, swappable for a vendor macro
module slave_bram #(
  parameter int N     = 8,
  parameter int DEPTH = 2048
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [N-1:0]             wdata,
  output logic [N-1:0]             rdata
);

  logic [N-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/bus_slave_burst.sv
// rtl/bus_slave_burst.sv - bit-serial bus slave with incrementing burst read/write into BRAM
module bus_slave_burst
  import bus_slave_pkg::*;
#(
  parameter int MemN   = 2,
  parameter int N      = 8,
  parameter int ADN    = 12,
  parameter int BLN    = 2,
  parameter int DelayN = 20
) (
  input  logic               clk,
  input  logic               rstn,
  bus_slave_burst_if.slave   bus,
  output logic [2:0]         state_out
);

  localparam int DEPTH = MemN * 1024;
  localparam int AW    = $clog2(DEPTH);
  localparam int HL    = hdrLen(ADN, BLN);
  localparam int HCW   = $clog2(HL) + 1;
  localparam int BCW   = $clog2(N) + 1;
  localparam int WCW   = BLN + 1;
  localparam int DCW   = $clog2(DelayN) + 1;
  localparam logic [ADN:0] DEPTH_L = (ADN+1)'(DEPTH);

  logic [2:0]     state, nextState;
  logic           readyReg;
  logic           mode;
  logic [HL-2:0]  hdrShift;
  logic [HCW-1:0] hdrCnt;
  logic [ADN-1:0] addr;
  logic [BLN-1:0] lenM1;
  logic [WCW-1:0] wordCnt;
  logic [BCW-1:0] bitCnt;
  logic [DCW-1:0] delayCnt;
  logic [N-2:0]   wrShift;
  logic           memWe;
  logic [AW-1:0]  memAddr;
  logic [N-1:0]   memWdata;
  logic [N-1:0]   rdata;
  logic           loadPend;
  logic           fetchOor;
  logic           haveWord;
  logic [N-1:0]   rdShift;
  logic [N-1:0]   nextWord;
  logic           sticky;

  logic [HL-1:0]  hdrFull;
  logic           hdrLast;
  logic           bitLast;
  logic           wordLast;
  logic           oor;
  logic           fetch;
  logic [AW-1:0]  bramAddr;
  logic [N-1:0]   fetchWord;

  assign hdrFull   = {hdrShift, bus.Address};
  assign hdrLast   = (state == HDR) && bus.validIn && (hdrCnt == HCW'(HL - 1));
  assign bitLast   = (bitCnt == BCW'(N - 1));
  assign wordLast  = (wordCnt == {1'b0, lenM1});
  assign oor       = ({1'b0, addr} >= DEPTH_L);
  assign fetchWord = fetchOor ? '0 : rdata;
  assign bramAddr  = memWe ? memAddr : addr[AW-1:0];

  // One fetch for the first word while waiting, then one per word at its first bit,
  // so the next word sits in nextWord well before the current word's last bit.
  assign fetch = ((state == RDWAIT) && !haveWord && !loadPend) ||
                 ((state == RD) && (bitCnt == '0) && !wordLast);

  slave_bram #(
    .N     (N),
    .DEPTH (DEPTH)
  ) uBram (
    .clk   (clk),
    .we    (memWe),
    .addr  (bramAddr),
    .wdata (memWdata),
    .rdata (rdata)
  );

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (readyReg && bus.validIn) nextState = HDR;
      HDR:     if (hdrLast) nextState = mode ? WR : RDWAIT;
      WR:      if (bus.validIn && bitLast && wordLast) nextState = DONE;
      RDWAIT:  if ((delayCnt >= DCW'(DelayN)) && bus.BusAvailable && haveWord) nextState = RD;
      RD:      if (bitLast && wordLast) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      readyReg <= 1'b0;
      mode     <= 1'b0;
      hdrShift <= '0;
      hdrCnt   <= '0;
      addr     <= '0;
      lenM1    <= '0;
      wordCnt  <= '0;
      bitCnt   <= '0;
      delayCnt <= '0;
      wrShift  <= '0;
      memWe    <= 1'b0;
      memAddr  <= '0;
      memWdata <= '0;
      loadPend <= 1'b0;
      fetchOor <= 1'b0;
      haveWord <= 1'b0;
      rdShift  <= '0;
      nextWord <= '0;
      sticky   <= 1'b0;
    end else begin
      state    <= nextState;
      readyReg <= (nextState == IDLE);
      memWe    <= 1'b0;
      loadPend <= fetch;

      if (fetch) begin
        fetchOor <= oor;
        addr     <= addr + ADN'(1);
        if (oor) sticky <= ERR_RANGE;
      end

      if (loadPend) begin
        if (state == RDWAIT) begin
          rdShift  <= fetchWord;
          haveWord <= 1'b1;
        end else begin
          nextWord <= fetchWord;
        end
      end

      case (state)
        IDLE: begin
          if (readyReg && bus.validIn) begin
            mode     <= bus.wren;
            hdrShift <= {{(HL-2){1'b0}}, bus.Address};
            hdrCnt   <= HCW'(1);
            bitCnt   <= '0;
            wordCnt  <= '0;
            delayCnt <= '0;
            haveWord <= 1'b0;
          end
        end
        HDR: begin
          if (bus.validIn) begin
            hdrShift <= hdrFull[HL-2:0];
            hdrCnt   <= hdrCnt + HCW'(1);
            if (hdrLast) begin
              addr  <= hdrFull[HL-1:BLN];
              lenM1 <= hdrFull[BLN-1:0];
            end
          end
        end
        WR: begin
          if (bus.validIn) begin
            wrShift <= {wrShift[N-3:0], bus.DataIn};
            if (bitLast) begin
              bitCnt  <= '0;
              wordCnt <= wordCnt + WCW'(1);
              addr    <= addr + ADN'(1);
              if (oor) begin
                sticky <= ERR_RANGE;
              end else begin
                memWe    <= 1'b1;
                memAddr  <= addr[AW-1:0];
                memWdata <= {wrShift, bus.DataIn};
              end
            end else begin
              bitCnt <= bitCnt + BCW'(1);
            end
          end
        end
        RDWAIT: begin
          if (delayCnt < DCW'(DelayN)) delayCnt <= delayCnt + DCW'(1);
        end
        RD: begin
          if (bitLast) begin
            bitCnt  <= '0;
            wordCnt <= wordCnt + WCW'(1);
            rdShift <= nextWord;
          end else begin
            bitCnt  <= bitCnt + BCW'(1);
            rdShift <= {rdShift[N-2:0], 1'b0};
          end
        end
        DONE:    sticky <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.ready    = readyReg;
  assign bus.validOut = (state == RD);
  assign bus.DataOut  = (state == RD) && rdShift[N-1];
  assign bus.err      = (state == DONE) && sticky;
  assign state_out    = state;

endmodule

// File: tb/tb_bus_slave_burst.sv
// tb/tb_bus_slave_burst.sv - directed self-checking bench for bus_slave_burst
module tb_bus_slave_burst;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [2:0] stateOut;
  int         checks = 0;
  int         errors = 0;

  bus_slave_burst_if bus();

  bus_slave_burst #(
    .MemN   (2),
    .N      (8),
    .ADN    (12),
    .BLN    (2),
    .DelayN (20)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .bus       (bus),
    .state_out (stateOut)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // wren is only meaningful on the first header bit, so it is inverted afterwards
  task automatic sendHeader(input bit wr, input logic [11:0] base, input logic [1:0] lf, input bit gaps);
    logic [13:0] h;
    h = {base, lf};
    for (int i = 13; i >= 0; i--) begin
      @(negedge clk);
      bus.validIn = 1'b1;
      bus.wren    = (i == 13) ? wr : !wr;
      bus.Address = h[i];
      if (gaps && i > 0) begin
        @(negedge clk);
        bus.validIn = 1'b0;
        bus.Address = !h[i];
      end
    end
  endtask

  task automatic runWrite(input logic [11:0] base, input logic [1:0] lf, input logic [31:0] wd,
                          input bit gaps, output int errs, output bit doneOk);
    errs = 0;
    doneOk = 1'b0;
    sendHeader(1'b1, base, lf, gaps);
    for (int w = 0; w <= int'(lf); w++) begin
      for (int b = 7; b >= 0; b--) begin
        @(negedge clk);
        bus.validIn = 1'b1;
        bus.DataIn  = wd[24 - 8*w + b];
      end
    end
    @(negedge clk);
    bus.validIn = 1'b0;
    bus.DataIn  = 1'b0;
    for (int j = 0; j < 10; j++) begin
      if (bus.err) errs++;
      if (bus.ready) begin
        doneOk = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic runRead(input logic [11:0] base, input logic [1:0] lf, input int holdBus,
                         output logic [31:0] data, output int waitCyc, output int nBits,
                         output int errs, output bit tailOk, output bit doneOk);
    data = '0;
    waitCyc = 0;
    nBits = 0;
    errs = 0;
    tailOk = 1'b0;
    doneOk = 1'b0;
    if (holdBus > 0) bus.BusAvailable = 1'b0;
    sendHeader(1'b0, base, lf, 1'b0);
    for (int j = 0; j < 300; j++) begin
      @(negedge clk);
      bus.validIn = 1'b0;
      bus.Address = 1'b0;
      if (bus.err) errs++;
      if (bus.validOut) break;
      waitCyc++;
      if (holdBus > 0 && j == holdBus) bus.BusAvailable = 1'b1;
    end
    if (bus.validOut) begin
      if (holdBus > 0) bus.BusAvailable = 1'b0;
      while (bus.validOut && nBits < 40) begin
        data = {data[30:0], bus.DataOut};
        nBits++;
        @(negedge clk);
        if (bus.err) errs++;
      end
      tailOk = !bus.validOut && !bus.DataOut;
      bus.BusAvailable = 1'b1;
      for (int j = 0; j < 10; j++) begin
        if (bus.ready) begin
          doneOk = 1'b1;
          break;
        end
        @(negedge clk);
        if (bus.err) errs++;
      end
    end
    bus.BusAvailable = 1'b1;
  endtask

  task automatic test_reset();
    bus.validIn = 1'b0;
    bus.wren = 1'b0;
    bus.Address = 1'b0;
    bus.DataIn = 1'b0;
    bus.BusAvailable = 1'b1;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", bus.ready); end
    checks++; if (bus.validOut !== 1'b0) begin errors++; $display("FAIL reset_validOut got %b want 0", bus.validOut); end
    checks++; if (bus.DataOut !== 1'b0) begin errors++; $display("FAIL reset_DataOut got %b want 0", bus.DataOut); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", bus.err); end
    checks++; if (stateOut !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", stateOut); end
    rstn = 1'b1;
    @(negedge clk);
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b want 1", bus.ready); end
  endtask

  task automatic test_single_word();
    int errs, waitCyc, nBits;
    bit ok, tailOk;
    logic [31:0] data;
    runWrite(12'h005, 2'd0, 32'hA500_0000, 1'b0, errs, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_wr_done got %b want 1", ok); end
    checks++; if (errs != 0) begin errors++; $display("FAIL single_wr_err got %0d want 0", errs); end
    runRead(12'h005, 2'd0, 0, data, waitCyc, nBits, errs, tailOk, ok);
    checks++; if (!(waitCyc >= 20)) begin errors++; $display("FAIL single_rd_wait got %0d want >=20", waitCyc); end
    checks++; if (nBits != 8) begin errors++; $display("FAIL single_rd_bits got %0d want 8", nBits); end
    checks++; if (data !== 32'h0000_00A5) begin errors++; $display("FAIL single_rd_data got %h want 000000a5", data); end
    checks++; if (errs != 0) begin errors++; $display("FAIL single_rd_err got %0d want 0", errs); end
    checks++; if (!tailOk) begin errors++; $display("FAIL single_rd_tail got %b want 1", tailOk); end
    checks++; if (!ok) begin errors++; $display("FAIL single_rd_done got %b want 1", ok); end
  endtask

  task automatic test_burst_end();
    int errs, waitCyc, nBits;
    bit ok, tailOk;
    logic [31:0] data;
    runWrite(12'h7FE, 2'd3, 32'h1122_3344, 1'b0, errs, ok);
    checks++; if (!ok) begin errors++; $display("FAIL burst_wr_done got %b want 1", ok); end
    checks++; if (errs != 1) begin errors++; $display("FAIL burst_wr_err got %0d want 1", errs); end
    runRead(12'h7FE, 2'd1, 0, data, waitCyc, nBits, errs, tailOk, ok);
    checks++; if (nBits != 16) begin errors++; $display("FAIL burst_rd_bits got %0d want 16", nBits); end
    checks++; if (data !== 32'h0000_1122) begin errors++; $display("FAIL burst_rd_data got %h want 00001122", data); end
    checks++; if (errs != 0) begin errors++; $display("FAIL burst_rd_err got %0d want 0", errs); end
  endtask

  task automatic test_bus_arb();
    int errs, waitCyc, nBits;
    bit ok, tailOk;
    logic [31:0] data;
    runRead(12'h7FE, 2'd1, 50, data, waitCyc, nBits, errs, tailOk, ok);
    checks++; if (waitCyc != 51) begin errors++; $display("FAIL arb_wait got %0d want 51", waitCyc); end
    checks++; if (nBits != 16) begin errors++; $display("FAIL arb_bits got %0d want 16", nBits); end
    checks++; if (data !== 32'h0000_1122) begin errors++; $display("FAIL arb_data got %h want 00001122", data); end
    checks++; if (!tailOk) begin errors++; $display("FAIL arb_tail got %b want 1", tailOk); end
  endtask

  task automatic test_hdr_gaps();
    int errs, waitCyc, nBits;
    bit ok, tailOk;
    logic [31:0] data;
    runWrite(12'h123, 2'd0, 32'h5A00_0000, 1'b1, errs, ok);
    checks++; if (!ok) begin errors++; $display("FAIL gaps_wr_done got %b want 1", ok); end
    runRead(12'h123, 2'd0, 0, data, waitCyc, nBits, errs, tailOk, ok);
    checks++; if (data !== 32'h0000_005A) begin errors++; $display("FAIL gaps_rd_data got %h want 0000005a", data); end
    runRead(12'h005, 2'd0, 0, data, waitCyc, nBits, errs, tailOk, ok);
    checks++; if (data !== 32'h0000_00A5) begin errors++; $display("FAIL gaps_other_data got %h want 000000a5", data); end
  endtask

  task automatic test_addr_wrap();
    int errs, waitCyc, nBits;
    bit ok, tailOk;
    logic [31:0] data;
    runWrite(12'h000, 2'd0, 32'h3C00_0000, 1'b0, errs, ok);
    checks++; if (errs != 0) begin errors++; $display("FAIL wrap_wr_err got %0d want 0", errs); end
    runRead(12'hFFF, 2'd1, 0, data, waitCyc, nBits, errs, tailOk, ok);
    checks++; if (nBits != 16) begin errors++; $display("FAIL wrap_bits got %0d want 16", nBits); end
    checks++; if (data !== 32'h0000_003C) begin errors++; $display("FAIL wrap_data got %h want 0000003c", data); end
    checks++; if (errs != 1) begin errors++; $display("FAIL wrap_err got %0d want 1", errs); end
  endtask

  task automatic test_reset_mid_read();
    int errs, waitCyc, nBits;
    bit ok, tailOk;
    logic [31:0] data;
    sendHeader(1'b0, 12'h123, 2'd0, 1'b0);
    for (int j = 0; j < 100; j++) begin
      @(negedge clk);
      bus.validIn = 1'b0;
      bus.Address = 1'b0;
      if (bus.validOut) break;
    end
    repeat (4) @(negedge clk);
    checks++;
    if (bus.validOut !== 1'b1 || bus.DataOut !== 1'b1) begin
      errors++; $display("FAIL midrd_bit5 got v=%b d=%b want v=1 d=1", bus.validOut, bus.DataOut);
    end
    rstn = 1'b0;
    #1;
    checks++; if (bus.validOut !== 1'b0) begin errors++; $display("FAIL midrd_validOut got %b want 0", bus.validOut); end
    checks++; if (bus.DataOut !== 1'b0) begin errors++; $display("FAIL midrd_DataOut got %b want 0", bus.DataOut); end
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL midrd_ready got %b want 0", bus.ready); end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL midrd_release_ready got %b want 1", bus.ready); end
    runRead(12'h123, 2'd0, 0, data, waitCyc, nBits, errs, tailOk, ok);
    checks++; if (data !== 32'h0000_005A) begin errors++; $display("FAIL midrd_reread got %h want 0000005a", data); end
    runRead(12'h7FE, 2'd1, 0, data, waitCyc, nBits, errs, tailOk, ok);
    checks++; if (data !== 32'h0000_1122) begin errors++; $display("FAIL midrd_reread2 got %h want 00001122", data); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_burst_end();
    test_bus_arb();
    test_hdr_gaps();
    test_addr_wrap();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
